// File: rtl/branch_resolve_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_pkg
// Shared definitions for the execute-stage branch resolution slice:
//   - condition-code encodings carried by the branch in EX
//   - FSM state encoding for the wrong-path shadow
//   - default parameter values (shadow depth, counter width)
// No ports (package).
// -----------------------------------------------------------------------------
package branch_resolve_unit_pkg;

   // Branch condition codes, evaluated against the registered N/Z/V flags
   localparam logic [2:0] CC_NEQ = 3'b000;
   localparam logic [2:0] CC_EQ  = 3'b001;
   localparam logic [2:0] CC_GT  = 3'b010;
   localparam logic [2:0] CC_LT  = 3'b011;
   localparam logic [2:0] CC_GTE = 3'b100;
   localparam logic [2:0] CC_LTE = 3'b101;
   localparam logic [2:0] CC_OVF = 3'b110;
   localparam logic [2:0] CC_UNC = 3'b111;

   // Number of younger wrong-path slots squashed after a taken branch (1..3)
   localparam int unsigned SHADOW_DEFAULT = 2;

   // Width of the branch/taken performance counters
   localparam int unsigned CNT_W_DEFAULT = 16;

   // Resolution FSM: either free to resolve, or squashing the shadow slots
   typedef enum logic {
      ST_IDLE        = 1'b0,
      ST_SHADOW_KILL = 1'b1
   } bru_state_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_if
// Bundles the pipeline-facing signals of the branch resolution unit.
//   master modport : pipeline side (drives branch/flags/stall, sees redirect)
//   slave  modport : branch_resolve_unit itself
// Signals:
//   stall, br_valid, br_cond[2:0], br_target[15:0], flag_n/z/v, cnt_clr  (to unit)
//   pc_redirect, pc_target[15:0], flush_if_id, flush_id_ex, ex_kill,
//   branch_cnt[CNT_W-1:0], taken_cnt[CNT_W-1:0]                         (from unit)
// -----------------------------------------------------------------------------
interface branch_resolve_unit_if
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
);

   logic              stall;
   logic              br_valid;
   logic [2:0]        br_cond;
   logic [15:0]       br_target;
   logic              flag_n;
   logic              flag_z;
   logic              flag_v;
   logic              cnt_clr;

   logic              pc_redirect;
   logic [15:0]       pc_target;
   logic              flush_if_id;
   logic              flush_id_ex;
   logic              ex_kill;
   logic [CNT_W-1:0]  branch_cnt;
   logic [CNT_W-1:0]  taken_cnt;

   modport master (
      output stall, br_valid, br_cond, br_target, flag_n, flag_z, flag_v, cnt_clr,
      input  pc_redirect, pc_target, flush_if_id, flush_id_ex, ex_kill,
             branch_cnt, taken_cnt
   );

   modport slave (
      input  stall, br_valid, br_cond, br_target, flag_n, flag_z, flag_v, cnt_clr,
      output pc_redirect, pc_target, flush_if_id, flush_id_ex, ex_kill,
             branch_cnt, taken_cnt
   );

endinterface

// File: rtl/branch_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_eval
// Pure combinational decode of a 3-bit condition code against N/Z/V flags.
// Kept separate so a future jump/return path can share the same decode.
// Ports:
//   br_cond [2:0] in  : condition code
//   n, z, v       in  : registered ALU flags
//   taken         out : 1 when the condition holds
// -----------------------------------------------------------------------------
module branch_cond_eval
   import branch_resolve_unit_pkg::*;
(
   input  logic [2:0] br_cond,
   input  logic       n,
   input  logic       z,
   input  logic       v,
   output logic       taken
);

   // GT/GTE/LTE treat N as the sign of the last result
   always_comb begin
      taken = 1'b0;
      unique case (br_cond)
         CC_NEQ: taken = ~z;
         CC_EQ:  taken = z;
         CC_GT:  taken = ~z & ~n;
         CC_LT:  taken = n;
         CC_GTE: taken = z | (~z & ~n);
         CC_LTE: taken = n | z;
         CC_OVF: taken = v;
         CC_UNC: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Execute-stage branch resolution. Evaluates the EX branch condition against
// the registered flags, redirects fetch and flushes IF/ID + ID/EX in the same
// cycle when taken, then holds ex_kill for SHADOW non-stalled cycles so the
// wrong-path instructions flowing through EX cannot update the ALU flags.
// Also keeps saturating branch/taken counters.
// Ports:
//   clk  in : system clock
//   rst  in : asynchronous active-high reset
//   bus     : branch_resolve_unit_if.slave (see interface for signal list)
// -----------------------------------------------------------------------------
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned SHADOW = SHADOW_DEFAULT,
   parameter int unsigned CNT_W  = CNT_W_DEFAULT
)(
   input  logic                 clk,
   input  logic                 rst,
   branch_resolve_unit_if.slave bus
);

   localparam int unsigned SC_W = $clog2(SHADOW + 1);

   bru_state_t        state;
   bru_state_t        next_state;
   logic [SC_W-1:0]   sc;
   logic [SC_W-1:0]   next_sc;

   logic              cond_true;
   logic              resolve;
   logic              taken;

   logic              pc_redirect;
   logic [15:0]       pc_target;
   logic              ex_kill;
   logic [CNT_W-1:0]  branch_cnt;
   logic [CNT_W-1:0]  taken_cnt;

   branch_cond_eval u_cond_eval (
      .br_cond (bus.br_cond),
      .n       (bus.flag_n),
      .z       (bus.flag_z),
      .v       (bus.flag_v),
      .taken   (cond_true)
   );

   // A branch only resolves when EX advances and we are not in a shadow slot
   assign resolve = bus.br_valid & ~bus.stall & (state == ST_IDLE);
   assign taken   = resolve & cond_true;

   // State register; a stall freezes both the state and the shadow count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         sc    <= '0;
      end else if (!bus.stall) begin
         state <= next_state;
         sc    <= next_sc;
      end
   end

   // Next-state logic; only consulted on non-stalled cycles
   always_comb begin
      next_state = state;
      next_sc    = sc;
      unique case (state)
         ST_IDLE: begin
            if (taken) begin
               next_state = ST_SHADOW_KILL;
               next_sc    = SC_W'(SHADOW);
            end
         end
         ST_SHADOW_KILL: begin
            if (sc <= SC_W'(1)) begin
               next_state = ST_IDLE;
               next_sc    = '0;
            end else begin
               next_sc = sc - SC_W'(1);
            end
         end
         default: begin
            next_state = ST_IDLE;
            next_sc    = '0;
         end
      endcase
   end

   // Outputs: redirect/flush are zero-latency from the inputs, ex_kill is a
   // decode of the registered state only so it cannot glitch into the ALU
   always_comb begin
      pc_redirect = taken;
      pc_target   = taken ? bus.br_target : 16'h0000;
      ex_kill     = (state == ST_SHADOW_KILL);
   end

   // Saturating performance counters; clear beats a same-cycle increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_cnt <= '0;
         taken_cnt  <= '0;
      end else if (bus.cnt_clr) begin
         branch_cnt <= '0;
         taken_cnt  <= '0;
      end else if (resolve) begin
         if (branch_cnt != '1) begin
            branch_cnt <= branch_cnt + CNT_W'(1);
         end
         if (taken && (taken_cnt != '1)) begin
            taken_cnt <= taken_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.pc_redirect = pc_redirect;
   assign bus.pc_target   = pc_target;
   assign bus.flush_if_id = pc_redirect;
   assign bus.flush_id_ex = pc_redirect;
   assign bus.ex_kill     = ex_kill;
   assign bus.branch_cnt  = branch_cnt;
   assign bus.taken_cnt   = taken_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed bench for branch_resolve_unit with a behavioural model of the
// shadow window and counters. Counters are narrowed to 8 bits so saturation
// is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

   localparam int unsigned SH   = 2;
   localparam int unsigned CW   = 8;
   localparam int          MAXV = (1 << CW) - 1;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   bit   ready;

   branch_resolve_unit_if #(.CNT_W(CW)) bus ();

   branch_resolve_unit #(.SHADOW(SH), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: remaining kill slots and plain integer counters
   int killLeft;
   int expBranch;
   int expTaken;

   function automatic bit condHolds(input logic [2:0] c, input bit n, input bit z, input bit v);
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || (!z && !n);
         3'd5: return n || z;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   function automatic bit modelResolves();
      return bus.br_valid && !bus.stall && (killLeft == 0);
   endfunction

   function automatic bit modelTaken();
      return modelResolves() && condHolds(bus.br_cond, bus.flag_n, bus.flag_z, bus.flag_v);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         killLeft  = 0;
         expBranch = 0;
         expTaken  = 0;
      end else begin
         bit res;
         bit tk;
         res = modelResolves();
         tk  = modelTaken();
         if (!bus.stall) begin
            if (killLeft > 0) killLeft = killLeft - 1;
            else if (tk) killLeft = SH;
         end
         if (bus.cnt_clr) begin
            expBranch = 0;
            expTaken  = 0;
         end else if (res) begin
            if (expBranch < MAXV) expBranch = expBranch + 1;
            if (tk && expTaken < MAXV) expTaken = expTaken + 1;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (ready && !rst) begin
         bit tk;
         tk = modelTaken();
         checkOutput("pc_redirect", 32'(bus.pc_redirect), 32'(tk));
         checkOutput("pc_target",   32'(bus.pc_target),   tk ? 32'(bus.br_target) : 32'h0);
         checkOutput("flush_if_id", 32'(bus.flush_if_id), 32'(tk));
         checkOutput("flush_id_ex", 32'(bus.flush_id_ex), 32'(tk));
         checkOutput("ex_kill",     32'(bus.ex_kill),     32'(killLeft > 0));
         checkOutput("branch_cnt",  32'(bus.branch_cnt),  32'(expBranch));
         checkOutput("taken_cnt",   32'(bus.taken_cnt),   32'(expTaken));
      end
   end

   task automatic applyStimulus(input bit v, input logic [2:0] c, input logic [15:0] t,
                                input bit n, input bit z, input bit fv,
                                input bit st, input bit clr);
      bus.br_valid  = v;
      bus.br_cond   = c;
      bus.br_target = t;
      bus.flag_n    = n;
      bus.flag_z    = z;
      bus.flag_v    = fv;
      bus.stall     = st;
      bus.cnt_clr   = clr;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int count);
      for (int i = 0; i < count; i++) begin
         stepCycle();
         applyStimulus(0, 3'd0, 16'h0, 0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      ready  = 1'b0;
      rst    = 1'b0;
      applyStimulus(0, 3'd0, 16'h0, 0, 0, 0, 0, 0);

      // Reset pulse mid-cycle: outputs must clear without a clock edge
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_redirect", 32'(bus.pc_redirect), 32'h0);
      checkOutput("rst_target",   32'(bus.pc_target),   32'h0);
      checkOutput("rst_ex_kill",  32'(bus.ex_kill),     32'h0);
      checkOutput("rst_branch",   32'(bus.branch_cnt),  32'h0);
      checkOutput("rst_taken",    32'(bus.taken_cnt),   32'h0);
      #5 rst = 1'b0;
      ready = 1'b1;

      // EQ taken, two shadow cycles
      stepCycle();
      applyStimulus(1, 3'b001, 16'h0040, 0, 1, 0, 0, 0);
      #2;
      checkOutput("eq_redirect", 32'(bus.pc_redirect), 32'h1);
      checkOutput("eq_target",   32'(bus.pc_target),   32'h0040);
      checkOutput("eq_flush_if", 32'(bus.flush_if_id), 32'h1);
      checkOutput("eq_flush_id", 32'(bus.flush_id_ex), 32'h1);
      idleCycles(1); #2 checkOutput("eq_kill1", 32'(bus.ex_kill), 32'h1);
      idleCycles(1); #2 checkOutput("eq_kill2", 32'(bus.ex_kill), 32'h1);
      idleCycles(1); #2 checkOutput("eq_kill3", 32'(bus.ex_kill), 32'h0);
      checkOutput("eq_branch", 32'(bus.branch_cnt), 32'd1);
      checkOutput("eq_taken",  32'(bus.taken_cnt),  32'd1);

      // LT not taken
      stepCycle();
      applyStimulus(1, 3'b011, 16'h1234, 0, 0, 0, 0, 0);
      #2 checkOutput("lt_redirect", 32'(bus.pc_redirect), 32'h0);
      idleCycles(1); #2;
      checkOutput("lt_kill",   32'(bus.ex_kill),    32'h0);
      checkOutput("lt_branch", 32'(bus.branch_cnt), 32'd2);
      checkOutput("lt_taken",  32'(bus.taken_cnt),  32'd1);

      // Stalled branch in IDLE does not resolve
      stepCycle();
      applyStimulus(1, 3'b111, 16'h2222, 0, 0, 0, 1, 0);
      #2 checkOutput("stall_idle_redirect", 32'(bus.pc_redirect), 32'h0);

      // UNCOND taken, then 3 stall cycles in the first shadow slot
      stepCycle();
      applyStimulus(1, 3'b111, 16'h0100, 0, 0, 0, 0, 0);
      #2 checkOutput("unc_redirect", 32'(bus.pc_redirect), 32'h1);
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         applyStimulus(0, 3'd0, 16'h0, 0, 0, 0, 1, 0);
         #2 checkOutput("stall_kill", 32'(bus.ex_kill), 32'h1);
      end
      idleCycles(1); #2 checkOutput("post_stall_kill1", 32'(bus.ex_kill), 32'h1);
      idleCycles(1); #2 checkOutput("post_stall_kill2", 32'(bus.ex_kill), 32'h1);
      idleCycles(1); #2 checkOutput("post_stall_kill3", 32'(bus.ex_kill), 32'h0);
      checkOutput("stall_branch", 32'(bus.branch_cnt), 32'd3);

      // Branch arriving in the shadow is squashed
      stepCycle();
      applyStimulus(1, 3'b111, 16'h0200, 0, 0, 0, 0, 0);
      stepCycle();
      applyStimulus(1, 3'b111, 16'h0300, 0, 0, 0, 0, 0);
      #2 checkOutput("shadow_redirect", 32'(bus.pc_redirect), 32'h0);
      idleCycles(2); #2;
      checkOutput("shadow_branch", 32'(bus.branch_cnt), 32'd4);
      checkOutput("shadow_taken",  32'(bus.taken_cnt),  32'd3);

      // Every condition against every flag combination (model-checked)
      for (int c = 0; c < 8; c++) begin
         for (int f = 0; f < 8; f++) begin
            stepCycle();
            applyStimulus(1, 3'(c), 16'(16'h1000 + c * 16 + f), f[2], f[1], f[0], 0, 0);
            idleCycles(SH);
         end
      end
      stepCycle();
      applyStimulus(1, 3'b100, 16'h0ABC, 0, 1, 0, 0, 0);
      #2 checkOutput("gte_z_redirect", 32'(bus.pc_redirect), 32'h1);
      idleCycles(SH);
      stepCycle();
      applyStimulus(1, 3'b010, 16'h0ABC, 0, 1, 0, 0, 0);
      #2 checkOutput("gt_z_redirect", 32'(bus.pc_redirect), 32'h0);

      // Clear with a simultaneous taken branch
      stepCycle();
      applyStimulus(1, 3'b111, 16'h0444, 0, 0, 0, 0, 1);
      #2 checkOutput("clr_redirect", 32'(bus.pc_redirect), 32'h1);
      idleCycles(1); #2;
      checkOutput("clr_branch", 32'(bus.branch_cnt), 32'd0);
      checkOutput("clr_taken",  32'(bus.taken_cnt),  32'd0);
      idleCycles(SH);

      // Saturation: more taken branches than the counter can hold
      for (int i = 0; i < MAXV + 5; i++) begin
         stepCycle();
         applyStimulus(1, 3'b111, 16'h0500, 0, 0, 0, 0, 0);
         idleCycles(SH);
      end
      stepCycle();
      applyStimulus(1, 3'b001, 16'h0600, 0, 0, 0, 0, 0);
      idleCycles(1); #2;
      checkOutput("sat_branch", 32'(bus.branch_cnt), 32'h0000_00FF);
      checkOutput("sat_taken",  32'(bus.taken_cnt),  32'h0000_00FF);

      // Reset in the middle of a shadow window
      stepCycle();
      applyStimulus(1, 3'b111, 16'h0700, 0, 0, 0, 0, 0);
      idleCycles(1);
      #2 checkOutput("mid_kill_before", 32'(bus.ex_kill), 32'h1);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_kill",   32'(bus.ex_kill),    32'h0);
      checkOutput("mid_rst_branch", 32'(bus.branch_cnt), 32'h0);
      checkOutput("mid_rst_taken",  32'(bus.taken_cnt),  32'h0);
      stepCycle();
      #2 rst = 1'b0;
      stepCycle();
      applyStimulus(1, 3'b000, 16'h0800, 0, 0, 0, 0, 0);
      #2;
      checkOutput("post_rst_redirect", 32'(bus.pc_redirect), 32'h1);
      checkOutput("post_rst_target",   32'(bus.pc_target),   32'h0800);
      idleCycles(SH + 1);

      #2;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage branch resolution block, sitting directly downstream of the 16-bit ALU flag registers (N, Z, V).
- Evaluates the 3-bit branch condition of the branch in EX against the registered flags, redirects fetch, and flushes the younger wrong-path instructions.
- Drives the hold signal back into the ALU so squashed shadow-slot instructions cannot update flags.
- Keeps saturating branch/taken performance counters.

Parameters:
- SHADOW, 2, number of wrong-path slots squashed after a taken branch (legal range 1..3)
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- stall  in  1  pipeline freeze from hazard unit; EX slot does not advance
- br_valid  in  1  EX instruction is a branch
- br_cond  in  3  condition code of the EX branch
- br_target  in  16  computed branch target PC
- flag_n  in  1  registered N flag from ALU
- flag_z  in  1  registered Z flag from ALU
- flag_v  in  1  registered V flag from ALU
- cnt_clr  in  1  synchronous clear of both counters
- pc_redirect  out  1  fetch must load pc_target this cycle
- pc_target  out  16  redirect PC
- flush_if_id  out  1  kill the IF/ID register contents
- flush_id_ex  out  1  kill the ID/EX register contents
- ex_kill  out  1  EX instruction is wrong-path; drives ALU prev_br_ctrl (flag hold)
- branch_cnt  out  CNT_W  resolved branches
- taken_cnt  out  CNT_W  taken branches

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock.
- Reset values: FSM in IDLE, shadow count 0, both counters 0. All outputs therefore read 0, with pc_target = 16'h0000.
- Condition decode (taken = 1 when true):
  - 000 NEQ: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: Z | (!Z & !N)
  - 101 LTE: N | Z
  - 110 OVFL: V
  - 111 UNCOND: 1
- Flags are used as presented this cycle; the ALU has already registered the result of the preceding instruction.
- A branch resolves in cycle T when br_valid & !stall & (state == IDLE).
- Resolution is combinational in cycle T, with zero latency:
  - pc_redirect = flush_if_id = flush_id_ex = taken
  - pc_target = br_target when taken, else 16'h0000
- FSM states: IDLE and SHADOW_KILL. A shadow counter sc has width sufficient for SHADOW.
  - IDLE -> SHADOW_KILL on a taken resolution; sc loads SHADOW.
  - In SHADOW_KILL, ex_kill = 1 (registered-state decode, glitch-free).
  - In SHADOW_KILL, br_valid is ignored: no redirect, no flush, no count.
  - Each !stall cycle in SHADOW_KILL decrements sc. When sc reaches 1 and !stall, return to IDLE.
  - SHADOW_KILL spans exactly SHADOW non-stalled cycles.
- stall = 1: FSM and sc hold. The branch in EX is not resolved (pc_redirect = 0), and counters hold. ex_kill keeps its state value.
- Counters:
  - branch_cnt increments on each resolution.
  - taken_cnt increments on each taken resolution.
  - Both saturate at all-ones with no wrap.
  - cnt_clr zeroes both at the next edge; cnt_clr wins over a simultaneous increment.
- Back-to-back taken branches: the second branch arrives in a shadow slot and is squashed, so there is no double redirect.
- Not-taken branch: no state change, branch_cnt + 1 only.
- rst asserted mid-shadow returns immediately to IDLE with ex_kill = 0. The counters clear.

Decomposition:
- Shared package holds:
  - condition-code localparams CC_NEQ..CC_UNC (3'b000..3'b111)
  - FSM state encodings
  - the SHADOW default
- One natural sub-module: branch_cond_eval, a pure combinational decode (br_cond, n, z, v) -> taken, reusable by a future jump/return path.
- The FSM and counters stay in the top module.

Test Plan:
- Reset then idle:
  - Stimulus: rst pulse mid-cycle, all inputs 0.
  - Required: all outputs 0 immediately (asynchronous), counters 0.
- EQ taken:
  - Stimulus: flags Z=1, br_cond=001, br_target=16'h0040, br_valid for 1 cycle.
  - Required: same cycle pc_redirect=1, pc_target=0040, both flushes 1.
  - Required: ex_kill=1 for next 2 cycles, then 0; branch_cnt=1, taken_cnt=1.
- LT not taken:
  - Stimulus: N=0, br_cond=011, br_valid=1.
  - Required: pc_redirect=0, ex_kill stays 0, branch_cnt+1, taken_cnt unchanged.
- Stall inside shadow:
  - Stimulus: UNCOND taken, then stall=1 for 3 cycles in the first shadow cycle.
  - Required: ex_kill held 1 through the stall; total kill duration = 2 non-stalled cycles + 3 stalled cycles.
- Branch in shadow / saturation:
  - Stimulus (shadow): taken branch followed next cycle by br_valid, br_cond=111.
    - Required: no second redirect, counts +1 only.
  - Stimulus (saturation): preload counts via 65535 taken branches.
    - Required: stays at 16'hFFFF.
  - Stimulus (clear): cnt_clr with a simultaneous branch.
    - Required: counters 0.
